// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder with a start/done handshake.
//   One LSB-first bit pair per cycle goes through a full-adder cell made of two
//   half_adder instances plus an OR. A carry flop links consecutive bits.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   start_i  add request, sampled in IDLE or DONE
//   a_i/b_i  operands, captured on an accepted start
//   cin_i    carry-in, captured on an accepted start
//   busy_o   high while the adder is shifting
//   done_o   one-cycle pulse, sum_o/cout_o valid
//   sum_o    result, held until the next accepted start
//   cout_o   carry-out of the MSB, same hold rule as sum_o

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic h_o,  // carry
  output logic l_o   // sum
);
  assign h_o = a_i & b_i;
  assign l_o = a_i ^ b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;

  // full-adder cell: ha0 adds the operand bits, ha1 folds in the carry
  logic h0, l0, h1, l1, fa_s, fa_c;
  half_adder u_ha0 (.a_i(sha_q[0]), .b_i(shb_q[0]), .h_o(h0), .l_o(l0));
  half_adder u_ha1 (.a_i(l0),       .b_i(carry_q),  .h_o(h1), .l_o(l1));
  assign fa_s = l1;
  assign fa_c = h0 | h1;

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    // flags lag the state by one edge so done follows the final sum bit
    busy_d  = (state_q == S_RUN);
    done_d  = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          sha_d   = a_i;
          shb_d   = b_i;
          carry_d = cin_i;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): reset values, latency, hand-computed
// sums, START during RUN, mid-run reset, back-to-back adds and random vectors.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge; inputs are driven and outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // steps until done (bounded); n = edges after the start edge, nb = busy cycles
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (busy) nb++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic do_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W:0] exp, input bit full);
    int n, nb;
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n, nb);
    chk({tag, ".sum"}, 32'(sum), 32'(exp[W-1:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(exp[W]));
    if (full) begin
      chk({tag, ".lat"}, 32'(n), 32'(W + 1));
      chk({tag, ".busy_cycles"}, 32'(nb), 32'(W));
      chk({tag, ".busy_at_done"}, 32'(busy), 32'(0));
      step();
      chk({tag, ".done_one_cycle"}, 32'(done), 32'(0));
    end else if (n < 0) begin
      chk({tag, ".timeout"}, 32'(n), 32'(W + 1));
    end
  endtask

  initial begin
    int n, nb, dcnt;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] rexp;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.sum",  32'(sum),  32'(0));
    chk("rst.cout", 32'(cout), 32'(0));
    step(); step();
    rst = 1'b0;
    step();

    do_add("t1", 8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
    do_add("t2", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    do_add("t3a", 8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
    do_add("t3b", 8'h3C, 8'h21, 1'b0, 9'h05D, 1'b1);
    do_add("t3c", 8'h80, 8'h80, 1'b1, 9'h101, 1'b1);

    // START and new operands during RUN are ignored
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (done) begin
        dcnt++;
        chk("t4.sum",  32'(sum),  32'(8'h47));
        chk("t4.cout", 32'(cout), 32'(0));
      end
    end
    chk("t4.done_count", 32'(dcnt), 32'(1));

    // reset 4 cycles into RUN: outputs clear without a clock, no DONE follows
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    #1;
    chk("t5.busy", 32'(busy), 32'(0));
    chk("t5.done", 32'(done), 32'(0));
    chk("t5.sum",  32'(sum),  32'(0));
    chk("t5.cout", 32'(cout), 32'(0));
    step();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) dcnt++;
    end
    chk("t5.no_activity", 32'(dcnt), 32'(0));
    do_add("t5.after", 8'h7F, 8'h01, 1'b1, 9'h081, 1'b1);

    // back-to-back with START held through DONE
    a = 8'hC8; b = 8'h64; cin = 1'b0; start = 1'b1;  // 200+100 = 300 = 9'h12C
    step();
    a = 8'h01; b = 8'h02; cin = 1'b1;                  // 4
    wait_done(n, nb);
    chk("t6.first_lat", 32'(n), 32'(W + 1));
    chk("t6.first_sum", 32'(sum), 32'(8'h2C));
    chk("t6.first_cout", 32'(cout), 32'(1));
    start = 1'b0;  // second add was accepted on the DONE edge
    step(); step(); step();
    chk("t6.cout_hold", 32'(cout), 32'(1));
    chk("t6.busy_mid", 32'(busy), 32'(1));
    n = 3;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      n++;
    end
    chk("t6.gap", 32'(n), 32'(W + 1));
    chk("t6.second_sum", 32'(sum), 32'(8'h04));
    chk("t6.second_cout", 32'(cout), 32'(0));
    step();

    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_add("rand", ra, rb, rc, rexp, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
